// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM write-port types, sizes and address mapping
package vram_pkg;

  localparam int VRAM_BYTES = 32768;
  localparam int VRAM_AW    = 15;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_LD,
    GNT_FILL
  } gnt_e;

  // Byte offset to plane-interleaved word address: bank bits move to the bottom.
  function automatic logic [VRAM_AW-1:0] vram_map(input logic [VRAM_AW-1:0] a);
    return {a[12:0], a[14:13]};
  endfunction

endpackage

// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - VRAM clear sequencer, advances one offset per grant
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               clear_req_i,
  input  logic               grant_i,
  output logic               busy_o,
  output logic [VRAM_AW-1:0] cnt_o
);

  logic               busy_q, busy_d;
  logic [VRAM_AW-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (grant_i) begin
      if (cnt_q == VRAM_AW'(VRAM_BYTES - 1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + VRAM_AW'(1);
      end
    end else if (clear_req_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  // busy_q is preloaded during reset so the fill can start on the first free cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy_q <= CLEAR_ON_RESET;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q & ~reset;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/vram_wr_sched.sv
// rtl/vram_wr_sched.sv - VRAM write-port arbiter: CPU > loader hold > fill engine
module vram_wr_sched
  import vram_pkg::*;
#(
  parameter logic [7:0] CLEAR_VALUE    = 8'h00,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_din,
  input  logic               cpu_we,
  input  logic [15:0]        ld_addr,
  input  logic [7:0]         ld_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic [VRAM_AW-1:0] vram_waddr,
  output logic [7:0]         vram_wdata,
  output logic               vram_wren
);

  logic               hold_valid_q, hold_valid_d;
  logic [15:0]        hold_addr_q, hold_addr_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic               wren_q, wren_d;
  logic [VRAM_AW-1:0] waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;

  logic               cpu_req, ld_req;
  logic [VRAM_AW-1:0] fill_cnt;
  gnt_e               gnt;

  assign cpu_req  = cpu_we & cpu_addr[15];
  assign ld_req   = hold_valid_q & hold_addr_q[15];
  assign ld_ready = ~hold_valid_q & ~reset;

  always_comb begin
    gnt = GNT_NONE;
    if (cpu_req)         gnt = GNT_CPU;
    else if (ld_req)     gnt = GNT_LD;
    else if (clear_busy) gnt = GNT_FILL;
  end

  vram_fill_engine #(
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_fill (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .clear_req_i(clear_req),
    .grant_i    (gnt == GNT_FILL),
    .busy_o     (clear_busy),
    .cnt_o      (fill_cnt)
  );

  // A held beat outside the VRAM window is dropped without a write.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (hold_valid_q && (gnt == GNT_LD || !hold_addr_q[15])) hold_valid_d = 1'b0;
    if (ld_valid && ld_ready) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = ld_addr;
      hold_data_d  = ld_data;
    end
  end

  always_comb begin
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (gnt)
      GNT_CPU: begin
        wren_d  = 1'b1;
        waddr_d = vram_map(cpu_addr[14:0]);
        wdata_d = cpu_din;
      end
      GNT_LD: begin
        wren_d  = 1'b1;
        waddr_d = vram_map(hold_addr_q[14:0]);
        wdata_d = hold_data_q;
      end
      GNT_FILL: begin
        wren_d  = 1'b1;
        waddr_d = vram_map(fill_cnt);
        wdata_d = CLEAR_VALUE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      wren_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      wren_q       <= wren_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign vram_wren  = wren_q;
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;

endmodule
